// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the decode/issue stage (package cpu_pkg).
package cpu_pkg;

  localparam int unsigned REG_W    = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 1 << REG_W;

  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned RD_MSB    = 11;
  localparam int unsigned RD_LSB    = 9;
  localparam int unsigned RS1_MSB   = 8;
  localparam int unsigned RS1_LSB   = 6;
  localparam int unsigned RS2_MSB   = 5;
  localparam int unsigned RS2_LSB   = 3;
  localparam int unsigned FUNCT_MSB = 2;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 5;

  typedef enum logic [3:0] {
    OpAlu  = 4'd0,
    OpAddi = 4'd1,
    OpLw   = 4'd2,
    OpSw   = 4'd3,
    OpBeq  = 4'd4,
    OpJal  = 4'd5,
    OpHalt = 4'd15
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [2:0]        funct;
    logic [REG_W-1:0]  rd;
    logic              we;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              illegal;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage; slave = the stage itself.
interface decode_stage_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;

  logic              out_valid;
  logic              out_ready;
  op_t               out_op;
  logic [2:0]        out_funct;
  logic [REG_W-1:0]  out_rd;
  logic              out_we;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_pc;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_funct, out_rd, out_we,
    input  out_a, out_b, out_imm, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_funct, out_rd, out_we,
    output out_a, out_b, out_imm, out_pc, out_illegal
  );

endinterface

// File: rtl/decode_stage_scoreboard.sv
// Per-register pending-write counters: +1 on issue, -1 on writeback or on a killed issue.
module scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned SB_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en_i,
  input  logic [REG_W-1:0]    set_rd_i,
  input  logic                clr_en_i,
  input  logic [REG_W-1:0]    clr_rd_i,
  input  logic                kill_en_i,
  input  logic [REG_W-1:0]    kill_rd_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [NUM_REGS-1:0] last_o,
  output logic [NUM_REGS-1:0] full_o
);

  logic [NUM_REGS-1:0][SB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      automatic int nxt = int'(cnt_q[r]);
      if (set_en_i && set_rd_i == REG_W'(r)) nxt = nxt + 1;
      // A writeback to an idle register is dropped rather than underflowing.
      if (clr_en_i && clr_rd_i == REG_W'(r) && cnt_q[r] != '0) nxt = nxt - 1;
      if (kill_en_i && kill_rd_i == REG_W'(r)) nxt = nxt - 1;
      if (nxt < 0) nxt = 0;
      cnt_d[r] = SB_W'(nxt);
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_o[r] = cnt_q[r] != '0;
      last_o[r] = clr_en_i && clr_rd_i == REG_W'(r) && cnt_q[r] == SB_W'(1);
      full_o[r] = &cnt_q[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode/issue stage with ID/EX register and pending-write scoreboard.
// Optional DECODE_ILLEGAL_TRAP_EN: flag opcodes 6-14 and block issue until flush.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       SB_W     = 2,
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_stage_if.slave       io,
  output logic [REG_W-1:0]    rf_rs1,
  output logic [REG_W-1:0]    rf_rs2,
  input  logic [DATA_W-1:0]   rf_rs1_data,
  input  logic [DATA_W-1:0]   rf_rs2_data,
  input  logic                wb_we,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam id_ex_t IdExRst = '{op: OpAlu, funct: '0, rd: '0, we: 1'b0, a: '0, b: '0,
                                 imm: '0, pc: RESET_PC, illegal: 1'b0};

  logic [DATA_W-1:0]   instr;
  logic [REG_W-1:0]    rd, rs1, rs2;
  op_t                 dec_op;
  logic                use_rs1, use_rs2, wr_op, dec_illegal, dec_we;
  logic                hazard, sat, in_ready, accept, kill_en;
  logic [NUM_REGS-1:0] busy, last, full;

  id_ex_t id_ex_q, id_ex_d;
  logic   out_valid_q, out_valid_d;
  logic   trap_q, trap_d;

  assign instr  = io.in_instr;
  assign rd     = instr[RD_MSB:RD_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  always_comb begin
    dec_op      = op_t'(instr[OP_MSB:OP_LSB]);
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    wr_op       = 1'b0;
    dec_illegal = 1'b0;
    case (dec_op)
      OpAlu:        begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_op = 1'b1; end
      OpAddi, OpLw: begin use_rs1 = 1'b1; wr_op = 1'b1; end
      OpSw, OpBeq:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OpJal:        wr_op = 1'b1;
      OpHalt:       begin end
      default:      dec_illegal = TrapEn;
    endcase
  end

  assign dec_we = wr_op && rd != '0;

  // A final writeback retiring this cycle is forwarded by the register file, so no stall.
  assign hazard = (use_rs1 && rs1 != '0 && busy[rs1] && !last[rs1]) ||
                  (use_rs2 && rs2 != '0 && busy[rs2] && !last[rs2]);
  assign sat    = dec_we && full[rd];

  assign in_ready = (!out_valid_q || io.out_ready) && !hazard && !sat && !flush && !trap_q;
  assign accept   = io.in_valid && in_ready;
  assign kill_en  = flush && out_valid_q && id_ex_q.we;

  scoreboard #(
    .SB_W (SB_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (accept && dec_we),
    .set_rd_i  (rd),
    .clr_en_i  (wb_we),
    .clr_rd_i  (wb_rd),
    .kill_en_i (kill_en),
    .kill_rd_i (id_ex_q.rd),
    .busy_o    (busy),
    .last_o    (last),
    .full_o    (full)
  );

  always_comb begin
    id_ex_d     = id_ex_q;
    out_valid_d = out_valid_q;
    trap_d      = trap_q;
    if (accept) begin
      id_ex_d = '{op: dec_op, funct: instr[FUNCT_MSB:FUNCT_LSB], rd: dec_we ? rd : '0,
                  we: dec_we, a: rf_rs1_data, b: rf_rs2_data,
                  imm: {{(DATA_W-IMM_MSB-1){instr[IMM_MSB]}}, instr[IMM_MSB:0]},
                  pc: io.in_pc, illegal: dec_illegal};
      out_valid_d = 1'b1;
      trap_d      = dec_illegal;
    end else if (flush) begin
      out_valid_d = 1'b0;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) trap_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q     <= IdExRst;
      out_valid_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      id_ex_q     <= id_ex_d;
      out_valid_q <= out_valid_d;
      trap_q      <= trap_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = out_valid_q;
  assign io.out_op      = id_ex_q.op;
  assign io.out_funct   = id_ex_q.funct;
  assign io.out_rd      = id_ex_q.rd;
  assign io.out_we      = id_ex_q.we;
  assign io.out_a       = id_ex_q.a;
  assign io.out_b       = id_ex_q.b;
  assign io.out_imm     = id_ex_q.imm;
  assign io.out_pc      = id_ex_q.pc;
  assign io.out_illegal = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage; expected ID/EX contents queued on accept.
module tb_decode_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  funct;
    logic [2:0]  rd;
    logic        we;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rf_rs1, rf_rs2;
  logic [15:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_rd = 3'd0;
  logic        flush = 1'b0;

  exp_t q[$];
  exp_t mon_e, mon_got;
  int   tests = 0, fails = 0, popped = 0;

  always #5 clk = ~clk;

  decode_stage_if io ();

  // Register file stand-in: data encodes the read address.
  assign rf_rs1_data = 16'hA000 | {13'd0, rf_rs1};
  assign rf_rs2_data = 16'hB000 | {13'd0, rf_rs2};

  decode_stage #(
    .SB_W     (2),
    .RESET_PC (16'h0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (io),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .flush       (flush)
  );

  function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    logic [3:0] op;
    op      = ins[15:12];
    e.op    = op;
    e.funct = ins[2:0];
    e.we    = (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd5) && ins[11:9] != 3'd0;
    e.rd    = e.we ? ins[11:9] : 3'd0;
    e.a     = 16'hA000 | {13'd0, ins[8:6]};
    e.b     = 16'hB000 | {13'd0, ins[5:3]};
    e.imm   = {{10{ins[5]}}, ins[5:0]};
    e.pc    = pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    e.illegal = op >= 4'd6 && op <= 4'd14;
`else
    e.illegal = 1'b0;
`endif
    return e;
  endfunction

  // Pop before push: an output always belongs to an earlier accept.
  always @(negedge clk) begin
    if (rst_n && io.out_valid && (io.out_ready || flush)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got out_pc=%h, required no output", io.out_pc);
      end else begin
        mon_e = q.pop_front();
        popped++;
        if (!flush) begin
          mon_got.op      = io.out_op;
          mon_got.funct   = io.out_funct;
          mon_got.rd      = io.out_rd;
          mon_got.we      = io.out_we;
          mon_got.a       = io.out_a;
          mon_got.b       = io.out_b;
          mon_got.imm     = io.out_imm;
          mon_got.pc      = io.out_pc;
          mon_got.illegal = io.out_illegal;
          tests++;
          if (mon_got !== mon_e) begin
            fails++;
            $display("FAIL out_fields pc=%h: got %h, required %h", mon_e.pc, mon_got, mon_e);
          end
        end
      end
    end
    if (rst_n && io.in_valid && io.in_ready) q.push_back(model(io.in_instr, io.in_pc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic retire(input logic [2:0] rd);
    tick();
    wb_we = 1'b1;
    wb_rd = rd;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset();
    io.in_valid  = 1'b1;
    io.in_instr  = 16'h1205;
    io.in_pc     = 16'h0004;
    io.out_ready = 1'b1;
    repeat (2) smp();
    tests++;
    if ({io.out_valid, io.out_op, io.out_funct, io.out_rd, io.out_we, io.out_a, io.out_b,
         io.out_imm, io.out_pc, io.out_illegal} !== {1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 16'h0,
         16'h0, 16'h0, 16'h0100, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got valid=%b pc=%h we=%b a=%h, required valid=0 pc=0100 we=0 a=0",
               io.out_valid, io.out_pc, io.out_we, io.out_a);
    end
    tick();
    rst_n       = 1'b1;
    io.in_valid = 1'b0;
    smp();
    tests++;
    if (io.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_handshake: got out_valid=%b, required 0", io.out_valid);
    end
  endtask

  task automatic test_addi();
    tick();
    io.in_valid = 1'b1;
    io.in_instr = 16'h1205;
    io.in_pc    = 16'h0010;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL addi_in_ready: got %b, required 1", io.in_ready);
    end
    tick();
    io.in_valid = 1'b0;
    smp();
    tests++;
    if ({io.out_valid, io.out_rd, io.out_we, io.out_imm} !== {1'b1, 3'd1, 1'b1, 16'h0005}) begin
      fails++;
      $display("FAIL addi_latency: got valid=%b rd=%0d we=%b imm=%h, required 1 1 1 0005",
               io.out_valid, io.out_rd, io.out_we, io.out_imm);
    end
  endtask

  task automatic test_hazard();
    tick();
    io.in_valid = 1'b1;
    io.in_instr = 16'h0448;
    io.in_pc    = 16'h0012;
    for (int i = 0; i < 2; i++) begin
      smp();
      tests++;
      if (io.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hazard_stall%0d: got in_ready=%b, required 0", i, io.in_ready);
      end
      tick();
    end
    wb_we = 1'b1;
    wb_rd = 3'd1;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hazard_wb_release: got in_ready=%b, required 1", io.in_ready);
    end
    tick();
    wb_we       = 1'b0;
    io.in_valid = 1'b0;
    smp();
    tests++;
    if ({io.out_a, io.out_b} !== {16'hA001, 16'hB001}) begin
      fails++;
      $display("FAIL hazard_operands: got a=%h b=%h, required a=a001 b=b001", io.out_a, io.out_b);
    end
    retire(3'd2);
  endtask

  task automatic test_back_to_back();
    tick();
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.in_instr  = 16'h1A3F;
    io.in_pc     = 16'h0020;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_accept: got in_ready=%b, required 1", io.in_ready);
    end
    tick();
    io.in_instr = 16'h5C03;
    io.in_pc    = 16'h0022;
    for (int i = 0; i < 3; i++) begin
      smp();
      tests++;
      if ({io.in_ready, io.out_valid, io.out_rd, io.out_imm} !== {1'b0, 1'b1, 3'd5, 16'hFFFF}) begin
        fails++;
        $display("FAIL bp_hold%0d: got ready=%b valid=%b rd=%0d imm=%h, required 0 1 5 ffff",
                 i, io.in_ready, io.out_valid, io.out_rd, io.out_imm);
      end
      tick();
    end
    io.out_ready = 1'b1;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_resume: got in_ready=%b, required 1", io.in_ready);
    end
    tick();
    io.in_valid = 1'b0;
    smp();
    tests++;
    if ({io.out_valid, io.out_rd} !== {1'b1, 3'd6}) begin
      fails++;
      $display("FAIL bp_no_bubble: got valid=%b rd=%0d, required 1 6", io.out_valid, io.out_rd);
    end
    retire(3'd5);
    retire(3'd6);
  endtask

  task automatic test_saturation();
    tick();
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.in_instr  = 16'h1601;
    io.in_pc     = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      smp();
      tests++;
      if (io.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL sat_accept%0d: got in_ready=%b, required 1", i, io.in_ready);
      end
      tick();
      io.in_pc = io.in_pc + 16'd2;
    end
    smp();
    tests++;
    if (io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL sat_full: got in_ready=%b, required 0", io.in_ready);
    end
    tick();
    wb_we = 1'b1;
    wb_rd = 3'd3;
    smp();
    tests++;
    if (io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL sat_wb_cycle: got in_ready=%b, required 0", io.in_ready);
    end
    tick();
    wb_we = 1'b0;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL sat_after_wb: got in_ready=%b, required 1", io.in_ready);
    end
    tick();
    io.in_valid = 1'b0;
    repeat (3) retire(3'd3);
  endtask

  task automatic test_flush();
    tick();
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.in_instr  = 16'h2842;
    io.in_pc     = 16'h0040;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_lw_accept: got in_ready=%b, required 1", io.in_ready);
    end
    tick();
    io.in_valid = 1'b0;
    smp();
    tests++;
    if (io.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_held: got out_valid=%b, required 1", io.out_valid);
    end
    tick();
    flush       = 1'b1;
    io.in_valid = 1'b1;
    io.in_instr = 16'h0F20;
    io.in_pc    = 16'h0042;
    smp();
    tests++;
    if (io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_blocks_issue: got in_ready=%b, required 0", io.in_ready);
    end
    tick();
    flush = 1'b0;
    smp();
    tests++;
    if ({io.out_valid, io.in_ready} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL flush_kill_no_stall: got valid=%b ready=%b, required 0 1",
               io.out_valid, io.in_ready);
    end
    tick();
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    smp();
    retire(3'd7);
  endtask

  task automatic test_wb_ignore();
    retire(3'd2);
    tick();
    io.in_valid = 1'b1;
    io.in_instr = 16'h1407;
    io.in_pc    = 16'h0050;
    smp();
    tick();
    io.in_instr = 16'h0681;
    io.in_pc    = 16'h0052;
    smp();
    tests++;
    if (io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL wbign_stall: got in_ready=%b, required 0", io.in_ready);
    end
    tick();
    wb_we = 1'b1;
    wb_rd = 3'd2;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL wbign_release: got in_ready=%b, required 1", io.in_ready);
    end
    tick();
    wb_we       = 1'b0;
    io.in_valid = 1'b0;
    retire(3'd3);
  endtask

  task automatic test_illegal();
    tick();
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.in_instr  = 16'hA200;
    io.in_pc     = 16'h0060;
    smp();
    tick();
    io.in_instr = 16'h1205;
    io.in_pc    = 16'h0062;
    smp();
`ifdef DECODE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (io.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL trap_stall%0d: got in_ready=%b, required 0", i, io.in_ready);
      end
      tick();
      smp();
    end
    tick();
    flush = 1'b1;
    smp();
    tick();
    flush = 1'b0;
    smp();
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL trap_released: got in_ready=%b, required 1", io.in_ready);
    end
`else
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL nop_no_stall: got in_ready=%b, required 1", io.in_ready);
    end
`endif
    tick();
    io.in_valid = 1'b0;
    smp();
    retire(3'd1);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.in_instr  = 16'h0;
    io.in_pc     = 16'h0;
    io.out_ready = 1'b0;
    test_reset();
    test_addi();
    test_hazard();
    test_back_to_back();
    test_saturation();
    test_flush();
    test_wb_ignore();
    test_illegal();
    smp();
    tests++;
    if (q.size() != 0 || popped != 14) begin
      fails++;
      $display("FAIL drain: got popped=%0d left=%0d, required popped=14 left=0", popped, q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
